// File: rtl/cfg_seq_pkg.sv
// Shared types for the AXI configuration sequencer: command opcodes, FSM states and AXI constants.
package cfg_seq_pkg;

  typedef enum logic [1:0] {
    WRITE = 2'b00,
    READ  = 2'b01,
    POLL  = 2'b10,
    RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_D = 3'd4,
    GAP  = 3'd5,
    RSP  = 3'd6
  } state_e;

  localparam logic [1:0] AXI_OKAY       = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // AXI size encoding for a full-width beat of the given byte count.
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/axi_cfg_sequencer.sv
// Single-outstanding AXI4 master turning WRITE / READ / POLL commands into single-beat register accesses.
// Optional macro CFG_SEQ_POLL_TIMEOUT_EN bounds POLL with a cycle timeout; without it POLL retries until match.
module axi_cfg_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int ID_WIDTH       = 4,
  parameter int POLL_GAP       = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // command / response
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [1:0]              cmd_op_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_data_i,
  input  logic [DATA_WIDTH-1:0]   cmd_mask_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic                    busy_o,
  // AW
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [2:0]              aw_size_o,
  output logic [ID_WIDTH-1:0]     aw_id_o,
  output logic [7:0]              aw_len_o,
  output logic [1:0]              aw_burst_o,
  // W
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  output logic                    w_last_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  // B
  input  logic [1:0]              b_resp_i,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  // AR
  output logic [ADDR_WIDTH-1:0]   ar_addr_o,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [2:0]              ar_size_o,
  output logic [ID_WIDTH-1:0]     ar_id_o,
  output logic [7:0]              ar_len_o,
  output logic [1:0]              ar_burst_o,
  // R
  input  logic [DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]              r_resp_i,
  input  logic                    r_last_i,
  input  logic                    r_valid_i,
  output logic                    r_ready_o
);

  localparam logic [2:0] AXI_SIZE = axi_size(DATA_WIDTH / 8);
  localparam int         GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  state_e                  state_q, state_d;
  cmd_op_e                 op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   mask_q, mask_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    poll_match;

`ifdef CFG_SEQ_POLL_TIMEOUT_EN
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_q, tmo_d;
`endif

  // Only masked bits take part in the compare, so a zero mask matches anything.
  assign poll_match = ((r_data_i ^ data_q) & mask_q) == '0;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mask_d    = mask_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    gap_d     = gap_q;
`ifdef CFG_SEQ_POLL_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          op_d      = cmd_op_e'(cmd_op_i);
          addr_d    = cmd_addr_i;
          data_d    = cmd_data_i;
          mask_d    = cmd_mask_i;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef CFG_SEQ_POLL_TIMEOUT_EN
          tmo_cnt_d = '0;
          tmo_d     = 1'b0;
`endif
          case (cmd_op_e'(cmd_op_i))
            WRITE:      state_d = WR;
            READ, POLL: state_d = RD_A;
            default: begin
              state_d = RSP;
              err_d   = 1'b1;
            end
          endcase
        end
      end

      WR: begin
        if (aw_ready_i) aw_done_d = 1'b1;
        if (w_ready_i)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_B;
      end

      WR_B: begin
        if (b_valid_i) begin
          err_d   = (b_resp_i != AXI_OKAY);
          state_d = RSP;
        end
      end

      RD_A: begin
        if (ar_ready_i) state_d = RD_D;
      end

      RD_D: begin
        if (r_valid_i) begin
          rdata_d = r_data_i;
          if (r_resp_i != AXI_OKAY) begin
            err_d   = 1'b1;
            state_d = RSP;
          end else if (op_q != POLL || poll_match) begin
            state_d = RSP;
          end else begin
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) state_d = RD_A;
        else                   gap_d   = gap_q + 1'b1;
`ifdef CFG_SEQ_POLL_TIMEOUT_EN
        // Only checked between reads so a bus transaction is never abandoned.
        if (tmo_cnt_q >= TMO_LIMIT) begin
          tmo_d   = 1'b1;
          state_d = RSP;
        end
`endif
      end

      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef CFG_SEQ_POLL_TIMEOUT_EN
    if (state_q == RD_A || state_q == RD_D || state_q == GAP) tmo_cnt_d = tmo_cnt_q + 32'd1;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= WRITE;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      gap_q     <= '0;
`ifdef CFG_SEQ_POLL_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      gap_q     <= gap_d;
`ifdef CFG_SEQ_POLL_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

`ifdef CFG_SEQ_POLL_TIMEOUT_EN
  assign rsp_timeout_o = tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign rsp_timeout_o  = 1'b0;
`endif

  // Single-beat reads: the last flag carries no information.
  logic unused_r_last;
  assign unused_r_last = r_last_i;

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_data_o  = rdata_q;
  assign rsp_err_o   = err_q;

  assign aw_addr_o   = addr_q;
  assign aw_valid_o  = (state_q == WR) && !aw_done_q;
  assign aw_size_o   = AXI_SIZE;
  assign aw_id_o     = '0;
  assign aw_len_o    = 8'd0;
  assign aw_burst_o  = AXI_BURST_INCR;

  assign w_data_o    = data_q;
  assign w_strb_o    = '1;
  assign w_last_o    = 1'b1;
  assign w_valid_o   = (state_q == WR) && !w_done_q;

  assign b_ready_o   = (state_q == WR_B);

  assign ar_addr_o   = addr_q;
  assign ar_valid_o  = (state_q == RD_A);
  assign ar_size_o   = AXI_SIZE;
  assign ar_id_o     = '0;
  assign ar_len_o    = 8'd0;
  assign ar_burst_o  = AXI_BURST_INCR;

  assign r_ready_o   = (state_q == RD_D);

endmodule
